// File: rtl/ranging_code_acquire.sv
// Serial code-phase search: correlates received chips against the local Gold code and
// slips the local code one chip per failed dwell until the period correlation reaches THRESH.
module ranging_code_acquire #(
    parameter int  CODE_LEN   = 1023,
    parameter int  THRESH     = 600,
    parameter int  SETTLE_CYC = 2,
    localparam int CORR_W     = $clog2(CODE_LEN + 1) + 1,
    localparam int PH_W       = $clog2(CODE_LEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     rx_chip,
    input  logic                     rx_valid,
    input  logic                     local_code,
    output logic                     shift_parse,
    output logic                     busy,
    output logic                     locked,
    output logic                     acq_fail,
    output logic [PH_W-1:0]          code_phase,
    output logic signed [CORR_W-1:0] corr_out
);
    localparam int CNT_W = $clog2(CODE_LEN + 1);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic signed [CORR_W-1:0] THR_S   = CORR_W'(THRESH);
    localparam logic signed [CORR_W-1:0] ONE_S   = CORR_W'(1);
    localparam logic signed [CORR_W-1:0] M_ONE_S = CORR_W'(-1);
    localparam logic signed [CORR_W-1:0] ACC_MIN = {1'b1, {(CORR_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_INTEG,
        S_DECIDE,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t                     r_state;
    logic [SET_W-1:0]           r_set_cnt;
    logic [CNT_W-1:0]           r_chip_cnt;
    logic [PH_W-1:0]            r_phase;
    logic [PH_W-1:0]            r_best;
    logic signed [CORR_W-1:0]   r_acc;
    logic signed [CORR_W-1:0]   r_peak;
    logic                       r_shift;
    logic                       r_busy;
    logic                       r_locked;
    logic                       r_fail;
    logic [PH_W-1:0]            r_code_phase;
    logic signed [CORR_W-1:0]   r_corr;

    logic                       w_agree;
    logic signed [CORR_W-1:0]   w_step;
    logic                       w_better;
    logic signed [CORR_W-1:0]   w_peak_nxt;
    logic [PH_W-1:0]            w_best_nxt;

    assign w_agree    = (rx_chip == local_code);
    assign w_step     = w_agree ? ONE_S : M_ONE_S;
    // Strict compare so a tie leaves the earlier phase as best.
    assign w_better   = (r_acc > r_peak);
    assign w_peak_nxt = w_better ? r_acc : r_peak;
    assign w_best_nxt = w_better ? r_phase : r_best;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_set_cnt    <= '0;
            r_chip_cnt   <= '0;
            r_phase      <= '0;
            r_best       <= '0;
            r_acc        <= '0;
            r_peak       <= '0;
            r_shift      <= 1'b0;
            r_busy       <= 1'b0;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
            r_code_phase <= '0;
            r_corr       <= '0;
        end else begin
            r_shift <= 1'b0;
            if (abort) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_locked <= 1'b0;
                r_fail   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_LOCKED, S_FAIL: begin
                        if (start) begin
                            r_state   <= S_SETTLE;
                            r_set_cnt <= '0;
                            r_phase   <= '0;
                            r_best    <= '0;
                            r_peak    <= ACC_MIN;
                            r_busy    <= 1'b1;
                            r_locked  <= 1'b0;
                            r_fail    <= 1'b0;
                        end
                    end
                    S_SETTLE: begin
                        r_acc      <= '0;
                        r_chip_cnt <= '0;
                        if (r_set_cnt == SET_W'(SETTLE_CYC - 1)) begin
                            r_state <= S_INTEG;
                        end else begin
                            r_set_cnt <= r_set_cnt + SET_W'(1);
                        end
                    end
                    S_INTEG: begin
                        if (rx_valid) begin
                            r_acc      <= r_acc + w_step;
                            r_chip_cnt <= r_chip_cnt + CNT_W'(1);
                            if (r_chip_cnt == CNT_W'(CODE_LEN - 1)) begin
                                r_state <= S_DECIDE;
                            end
                        end
                    end
                    S_DECIDE: begin
                        r_peak <= w_peak_nxt;
                        r_best <= w_best_nxt;
                        if (r_acc >= THR_S) begin
                            r_state      <= S_LOCKED;
                            r_busy       <= 1'b0;
                            r_locked     <= 1'b1;
                            r_code_phase <= r_phase;
                            r_corr       <= r_acc;
                        end else if (r_phase == PH_W'(CODE_LEN - 1)) begin
                            r_state      <= S_FAIL;
                            r_busy       <= 1'b0;
                            r_fail       <= 1'b1;
                            r_code_phase <= w_best_nxt;
                            r_corr       <= w_peak_nxt;
                        end else begin
                            // Raised here so the pulse coincides with the SLIP cycle.
                            r_state <= S_SLIP;
                            r_shift <= 1'b1;
                        end
                    end
                    S_SLIP: begin
                        r_phase   <= r_phase + PH_W'(1);
                        r_set_cnt <= '0;
                        r_state   <= S_SETTLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign shift_parse = r_shift;
    assign busy        = r_busy;
    assign locked      = r_locked;
    assign acq_fail    = r_fail;
    assign code_phase  = r_code_phase;
    assign corr_out    = r_corr;

endmodule

// File: tb/tb_ranging_code_acquire.sv
// Bench for ranging_code_acquire: a 31-chip m-sequence generator model that honours
// shift_parse, plus a reference search model feeding an expected-result queue.
module tb_ranging_code_acquire;
    localparam int LEN    = 31;
    localparam int THR    = 25;
    localparam int SET    = 2;
    localparam int PH_W   = 5;
    localparam int CORR_W = 6;
    localparam int DWELL  = SET + LEN + 2;

    logic clk = 1'b0;
    logic rst_n, start, abort, rx_chip, rx_valid, local_code;
    logic shift_parse, busy, locked, acq_fail;
    logic [PH_W-1:0] code_phase;
    logic signed [CORR_W-1:0] corr_out;

    typedef struct {
        bit lock;
        int phase;
        int corr;
        int pulses;
    } exp_t;

    exp_t sb[$];
    bit   seq[LEN];
    int   ridx, lidx;
    bit   alt_mode, zero_mode;
    int   cyc, n_pulses, n_wide, low_run, gap_min, gap_max;
    bit   prev_sp;
    int   n_chk, n_fail;

    ranging_code_acquire #(.CODE_LEN(LEN), .THRESH(THR), .SETTLE_CYC(SET)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rx_chip(rx_chip), .rx_valid(rx_valid), .local_code(local_code),
        .shift_parse(shift_parse), .busy(busy), .locked(locked), .acq_fail(acq_fail),
        .code_phase(code_phase), .corr_out(corr_out)
    );

    always #5 clk = ~clk;

    task automatic drive();
        rx_chip    = zero_mode ? 1'b0 : seq[ridx];
        local_code = seq[lidx];
    endtask

    task automatic clear_stats();
        n_pulses = 0; n_wide = 0; low_run = 0;
        gap_min = 1000000; gap_max = 0; prev_sp = 1'b0;
    endtask

    // d: local code leads the received code by d chips
    task automatic setup(input int d, input bit zero, input bit alt);
        ridx = 0; lidx = d % LEN;
        zero_mode = zero; alt_mode = alt;
        rx_valid = 1'b1;
        drive();
        clear_stats();
    endtask

    task automatic tick();
        logic sp;
        @(negedge clk);
        sp = shift_parse;
        if (sp) begin
            if (prev_sp) n_wide++;
            if (n_pulses > 0) begin
                if (low_run < gap_min) gap_min = low_run;
                if (low_run > gap_max) gap_max = low_run;
            end
            n_pulses++;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_sp = sp;
        @(posedge clk);
        #1;
        cyc++;
        if (rx_valid) ridx = (ridx + 1) % LEN;
        lidx = (lidx + (rx_valid ? 1 : 0) - (sp ? 1 : 0) + LEN) % LEN;
        rx_valid = alt_mode ? !rx_valid : 1'b1;
        drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (locked || acq_fail) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic exp_t model(input int d, input bit zero);
        exp_t e;
        int   peak, best, c;
        bit   r, l;
        peak = -1000; best = 0;
        for (int k = 0; k < LEN; k++) begin
            c = 0;
            for (int i = 0; i < LEN; i++) begin
                r = zero ? 1'b0 : seq[i];
                l = seq[((i + d - k) % LEN + LEN) % LEN];
                c += (r == l) ? 1 : -1;
            end
            if (c > peak) begin
                peak = c;
                best = k;
            end
            if (c >= THR) begin
                e.lock = 1'b1; e.phase = k; e.corr = c; e.pulses = k;
                return e;
            end
        end
        e.lock = 1'b0; e.phase = best; e.corr = peak; e.pulses = LEN - 1;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(3);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (locked !== 1'b0 || acq_fail !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got locked=%b fail=%b want 0 0", locked, acq_fail); end
        n_chk++; if (code_phase !== '0 || corr_out !== '0) begin n_fail++; $display("FAIL reset_values: got phase=%0d corr=%0d want 0 0", code_phase, corr_out); end
        n_chk++; if (shift_parse !== 1'b0) begin n_fail++; $display("FAIL reset_shift: got %b want 0", shift_parse); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_aligned();
        exp_t e;
        bit   ok;
        int   c0;
        setup(0, 1'b0, 1'b0);
        sb.push_back(model(0, 1'b0));
        c0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        wait_done(200, ok);
        e = sb.pop_front();
        n_chk++; if (!ok) begin n_fail++; $display("FAIL aligned_timeout: got no result want lock within 200 cycles"); end
        n_chk++; if (cyc - c0 !== DWELL) begin n_fail++; $display("FAIL aligned_latency: got %0d want %0d", cyc - c0, DWELL); end
        n_chk++; if (locked !== e.lock || acq_fail !== 1'b0) begin n_fail++; $display("FAIL aligned_lock: got locked=%b fail=%b want %b 0", locked, acq_fail, e.lock); end
        n_chk++; if (int'(code_phase) !== e.phase) begin n_fail++; $display("FAIL aligned_phase: got %0d want %0d", code_phase, e.phase); end
        n_chk++; if (int'(corr_out) !== e.corr) begin n_fail++; $display("FAIL aligned_corr: got %0d want %0d", corr_out, e.corr); end
        n_chk++; if (n_pulses !== e.pulses) begin n_fail++; $display("FAIL aligned_pulses: got %0d want %0d", n_pulses, e.pulses); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL aligned_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        setup(5, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        ticks(10);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_chk++; if (busy !== 1'b0 || locked !== 1'b0 || acq_fail !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got busy=%b locked=%b fail=%b want 0 0 0", busy, locked, acq_fail); end
        n_chk++; if (code_phase !== '0 || corr_out !== '0) begin n_fail++; $display("FAIL midreset_values: got phase=%0d corr=%0d want 0 0", code_phase, corr_out); end
        n_chk++; if (shift_parse !== 1'b0) begin n_fail++; $display("FAIL midreset_shift: got %b want 0", shift_parse); end
        ticks(40);
        n_chk++; if (busy !== 1'b0 || n_pulses !== 0) begin n_fail++; $display("FAIL midreset_idle: got busy=%b pulses=%0d want 0 0", busy, n_pulses); end
    endtask

    task automatic test_offset5();
        exp_t e;
        bit   ok;
        int   c0;
        setup(5, 1'b0, 1'b0);
        sb.push_back(model(5, 1'b0));
        c0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        wait_done(1500, ok);
        e = sb.pop_front();
        n_chk++; if (!ok) begin n_fail++; $display("FAIL offset5_timeout: got no result want lock within 1500 cycles"); end
        n_chk++; if (locked !== e.lock) begin n_fail++; $display("FAIL offset5_lock: got %b want %b", locked, e.lock); end
        n_chk++; if (int'(code_phase) !== e.phase) begin n_fail++; $display("FAIL offset5_phase: got %0d want %0d", code_phase, e.phase); end
        n_chk++; if (int'(corr_out) !== e.corr) begin n_fail++; $display("FAIL offset5_corr: got %0d want %0d", corr_out, e.corr); end
        n_chk++; if (n_pulses !== e.pulses) begin n_fail++; $display("FAIL offset5_pulses: got %0d want %0d", n_pulses, e.pulses); end
        n_chk++; if (n_wide !== 0) begin n_fail++; $display("FAIL offset5_width: got %0d wide pulses want 0", n_wide); end
        n_chk++; if (gap_min !== DWELL - 1 || gap_max !== DWELL - 1) begin n_fail++; $display("FAIL offset5_gap: got min=%0d max=%0d want %0d", gap_min, gap_max, DWELL - 1); end
        n_chk++; if (cyc - c0 !== DWELL * (e.phase + 1)) begin n_fail++; $display("FAIL offset5_latency: got %0d want %0d", cyc - c0, DWELL * (e.phase + 1)); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        int   c0, d;
        d = (lidx - ridx + LEN) % LEN;
        clear_stats();
        sb.push_back(model(d, 1'b0));
        c0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        n_chk++; if (locked !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_flags: got locked=%b busy=%b want 0 1", locked, busy); end
        wait_done(200, ok);
        e = sb.pop_front();
        n_chk++; if (!ok || locked !== e.lock) begin n_fail++; $display("FAIL restart_lock: got ok=%b locked=%b want 1 %b", ok, locked, e.lock); end
        n_chk++; if (int'(code_phase) !== e.phase || int'(corr_out) !== e.corr) begin n_fail++; $display("FAIL restart_result: got phase=%0d corr=%0d want %0d %0d", code_phase, corr_out, e.phase, e.corr); end
        n_chk++; if (n_pulses !== e.pulses || cyc - c0 !== DWELL) begin n_fail++; $display("FAIL restart_timing: got pulses=%0d lat=%0d want %0d %0d", n_pulses, cyc - c0, e.pulses, DWELL); end
        abort = 1'b1; tick(); abort = 1'b0;
        n_chk++; if (locked !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_locked: got locked=%b busy=%b want 0 0", locked, busy); end
    endtask

    task automatic test_no_lock();
        exp_t e;
        bit   ok;
        setup(0, 1'b1, 1'b0);
        sb.push_back(model(0, 1'b1));
        start = 1'b1; tick(); start = 1'b0;
        wait_done(DWELL * LEN + 50, ok);
        e = sb.pop_front();
        n_chk++; if (!ok) begin n_fail++; $display("FAIL nolock_timeout: got no result want fail within %0d cycles", DWELL * LEN + 50); end
        n_chk++; if (acq_fail !== 1'b1 || locked !== e.lock) begin n_fail++; $display("FAIL nolock_flags: got fail=%b locked=%b want 1 %b", acq_fail, locked, e.lock); end
        n_chk++; if (int'(code_phase) !== e.phase) begin n_fail++; $display("FAIL nolock_phase: got %0d want %0d", code_phase, e.phase); end
        n_chk++; if (int'(corr_out) !== e.corr) begin n_fail++; $display("FAIL nolock_corr: got %0d want %0d", corr_out, e.corr); end
        n_chk++; if (n_pulses !== e.pulses || n_wide !== 0) begin n_fail++; $display("FAIL nolock_pulses: got %0d wide=%0d want %0d 0", n_pulses, n_wide, e.pulses); end
        ticks(5);
        n_chk++; if (acq_fail !== 1'b1 || n_pulses !== e.pulses) begin n_fail++; $display("FAIL nolock_hold: got fail=%b pulses=%0d want 1 %0d", acq_fail, n_pulses, e.pulses); end
    endtask

    task automatic test_gapped_valid();
        exp_t e;
        bit   ok;
        int   c0;
        setup(3, 1'b0, 1'b1);
        sb.push_back(model(3, 1'b0));
        c0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        wait_done(2000, ok);
        e = sb.pop_front();
        n_chk++; if (!ok || locked !== e.lock) begin n_fail++; $display("FAIL gapped_lock: got ok=%b locked=%b want 1 %b", ok, locked, e.lock); end
        n_chk++; if (int'(code_phase) !== e.phase) begin n_fail++; $display("FAIL gapped_phase: got %0d want %0d", code_phase, e.phase); end
        n_chk++; if (int'(corr_out) !== e.corr) begin n_fail++; $display("FAIL gapped_corr: got %0d want %0d", corr_out, e.corr); end
        n_chk++; if (n_pulses !== e.pulses) begin n_fail++; $display("FAIL gapped_pulses: got %0d want %0d", n_pulses, e.pulses); end
        n_chk++; if (cyc - c0 < (e.phase + 1) * (2 * LEN)) begin n_fail++; $display("FAIL gapped_duration: got %0d want at least %0d", cyc - c0, (e.phase + 1) * (2 * LEN)); end
        alt_mode = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_abort_and_start();
        exp_t e;
        bit   ok;
        setup(2, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        abort = 1'b1; tick(); abort = 1'b0;
        n_chk++; if (busy !== 1'b0 || shift_parse !== 1'b0) begin n_fail++; $display("FAIL abort_settle: got busy=%b shift=%b want 0 0", busy, shift_parse); end
        ticks(3);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b want 0", busy); end
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        ticks(2);
        n_chk++; if (busy !== 1'b0 || n_pulses !== 0) begin n_fail++; $display("FAIL abort_wins: got busy=%b pulses=%0d want 0 0", busy, n_pulses); end

        setup(2, 1'b0, 1'b0);
        sb.push_back(model(2, 1'b0));
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 200 && n_pulses == 0; i++) tick();
        ticks(5);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(300, ok);
        e = sb.pop_front();
        n_chk++; if (!ok || locked !== e.lock) begin n_fail++; $display("FAIL busy_start_lock: got ok=%b locked=%b want 1 %b", ok, locked, e.lock); end
        n_chk++; if (int'(code_phase) !== e.phase) begin n_fail++; $display("FAIL busy_start_phase: got %0d want %0d", code_phase, e.phase); end
        n_chk++; if (n_pulses !== e.pulses) begin n_fail++; $display("FAIL busy_start_pulses: got %0d want %0d", n_pulses, e.pulses); end
    endtask

    initial begin
        logic [4:0] lfsr;
        lfsr = 5'b00001;
        for (int i = 0; i < LEN; i++) begin
            seq[i] = lfsr[0];
            lfsr   = {lfsr[0] ^ lfsr[2], lfsr[4:1]};
        end
        n_chk = 0; n_fail = 0; cyc = 0;
        start = 1'b0; abort = 1'b0; rst_n = 1'b0;
        setup(0, 1'b0, 1'b0);

        test_reset();
        test_aligned();
        test_reset_mid();
        test_offset5();
        test_back_to_back();
        test_no_lock();
        test_gapped_valid();
        test_abort_and_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
